pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the pipelined CPU, replacing the fixed per-boundary latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one configurable block. It carries a payload bus and a control bus through `DEPTH` chained register stages, each with its own valid bit. A global stall freezes every stage, and a flush kills all in-flight entries as bubbles. An optional statistics unit counts stall and bubble cycles for performance analysis.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/pipe_stage_cell.sv | 60 ++++++
 rtl/pipe_stage_reg.sv | 83 ++++++++
 tb/tb_pipe_stage_reg.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: default bus widths,
// control-bit positions and the per-stage update decision.
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_CTRL_W = 8;

  // Control-bus bit positions; bits 5..7 are reserved.
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_BRANCH   = 4;

  // Saturation value for the statistics counters.
  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    CELL_LOAD  = 2'd0,
    CELL_HOLD  = 2'd1,
    CELL_FLUSH = 2'd2
  } cell_op_e;

  // Flush has priority over stall; otherwise the stage loads from upstream.
  function automatic cell_op_e cell_op(input logic flush, input logic stall);
    if (flush) return CELL_FLUSH;
    if (stall) return CELL_HOLD;
    return CELL_LOAD;
  endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// One pipeline register stage: valid, control and payload registers with
// flush/stall/load update. Control is only ever non-zero alongside valid=1.
module pipe_stage_cell
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  cell_op_e w_op;
  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  assign w_op = cell_op(flush_i, stall_i);

  // Stage registers: flush kills the entry but still moves the payload along,
  // stall freezes everything, otherwise load with control gated by valid.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else begin
      case (w_op)
        CELL_FLUSH: begin
          r_valid <= 1'b0;
          r_ctrl  <= '0;
          r_data  <= data_i;
        end
        CELL_HOLD: begin
          r_valid <= r_valid;
          r_ctrl  <= r_ctrl;
          r_data  <= r_data;
        end
        default: begin
          r_valid <= valid_i;
          r_ctrl  <= valid_i ? ctrl_i : '0;
          r_data  <= data_i;
        end
      endcase
    end
  end

  assign valid_o = r_valid;
  assign ctrl_o  = r_ctrl;
  assign data_o  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Configurable inter-stage pipeline register: DEPTH chained stages (legal
// range 1..8) sharing one stall and one flush. Optional stall/bubble
// statistics are built only when PIPE_REG_STATS_EN is defined.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int DEPTH  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
`ifdef PIPE_REG_STATS_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       bubble_cnt_o
`endif
);

  // Index 0 is the block input, index k+1 is the output of stage k.
  logic              w_valid [DEPTH+1];
  logic [CTRL_W-1:0] w_ctrl  [DEPTH+1];
  logic [DATA_W-1:0] w_data  [DEPTH+1];

  assign w_valid[0] = valid_i;
  assign w_ctrl[0]  = ctrl_i;
  assign w_data[0]  = data_i;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    pipe_stage_cell #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
    ) u_cell (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .stall_i (stall_i),
      .flush_i (flush_i),
      .valid_i (w_valid[g]),
      .ctrl_i  (w_ctrl[g]),
      .data_i  (w_data[g]),
      .valid_o (w_valid[g+1]),
      .ctrl_o  (w_ctrl[g+1]),
      .data_o  (w_data[g+1])
    );
  end

  assign valid_o = w_valid[DEPTH];
  assign ctrl_o  = w_ctrl[DEPTH];
  assign data_o  = w_data[DEPTH];

`ifdef PIPE_REG_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  // Saturating counters: a stall that coincides with a flush is not counted,
  // and a bubble is an edge where the last stage currently holds no entry.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (stall_i && !flush_i && (r_stall_cnt != STAT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (!w_valid[DEPTH] && (r_bubble_cnt != STAT_MAX)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt_o  = r_stall_cnt;
  assign bubble_cnt_o = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (DEPTH 1, 2, 3) share one input
// stream; each has a queue-based reference model alongside it.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [7:0]  c;
    logic [31:0] d;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        stall_s;
  logic        flush_s;
  logic        valid_s;
  logic [7:0]  ctrl_s;
  logic [31:0] data_s;

  logic        vo   [3];
  logic [7:0]  co   [3];
  logic [31:0] dout [3];
`ifdef PIPE_REG_STATS_EN
  logic [31:0] sco  [3];
  logic [31:0] bco  [3];
  wire  [31:0] exp_sc [3];
  wire  [31:0] exp_bc [3];
`endif
  wire  [40:0] exp_w [3];
  wire  [40:0] got_w [3];

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_m
    localparam int D = k + 1;

    pipe_stage_reg #(
      .DATA_W (32),
      .CTRL_W (8),
      .DEPTH  (D)
    ) u_dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .stall_i      (stall_s),
      .flush_i      (flush_s),
      .valid_i      (valid_s),
      .ctrl_i       (ctrl_s),
      .data_i       (data_s),
      .valid_o      (vo[k]),
      .ctrl_o       (co[k]),
      .data_o       (dout[k])
`ifdef PIPE_REG_STATS_EN
      ,
      .stall_cnt_o  (sco[k]),
      .bubble_cnt_o (bco[k])
`endif
    );

    // Reference: per-stage occupancy bits give timing, a FIFO of captured
    // entries gives content; cur is the entry expected at the output.
    logic [7:0]  mv;
    logic [7:0]  nx;
    ent_t        cur;
    ent_t        q[$];
    logic [31:0] sc;
    logic [31:0] bc;

    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        mv = '0;
        cur = '0;
        q.delete();
        sc = '0;
        bc = '0;
      end else begin
        if (!mv[D-1] && bc != 32'hFFFF_FFFF) bc = bc + 1;
        if (flush_s) begin
          mv = '0;
          q.delete();
        end else if (stall_s) begin
          if (sc != 32'hFFFF_FFFF) sc = sc + 1;
        end else begin
          nx = {mv[6:0], valid_s};
          if (valid_s) q.push_back('{c: ctrl_s, d: data_s});
          if (nx[D-1]) begin
            if (q.size() > 0) cur = q.pop_front();
            else cur = '0;
          end
          mv = nx;
        end
      end
    end

    assign exp_w[k] = {mv[D-1], mv[D-1] ? cur : 40'h0};
    assign got_w[k] = {vo[k], co[k], vo[k] ? dout[k] : 32'h0};
`ifdef PIPE_REG_STATS_EN
    assign exp_sc[k] = sc;
    assign exp_bc[k] = bc;
`endif
  end

  task automatic drive(input logic v, input logic [7:0] c, input logic [31:0] d,
                       input logic s, input logic f);
    valid_s = v;
    ctrl_s  = c;
    data_s  = d;
    stall_s = s;
    flush_s = f;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 8'h1F, 32'hDEAD_BEEF, 1'b0, 1'b0);
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({vo[k], co[k], dout[k]} !== 41'h0) begin
          errors++;
          $display("FAIL reset d%0d: got v=%0b c=%h d=%h, want all zero", k+1, vo[k], co[k], dout[k]);
        end
`ifdef PIPE_REG_STATS_EN
        checks++;
        if (sco[k] !== 32'h0 || bco[k] !== 32'h0) begin
          errors++;
          $display("FAIL reset_cnt d%0d: got stall=%0d bubble=%0d, want 0 0", k+1, sco[k], bco[k]);
        end
`endif
      end
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 8'h05, 32'd1, 1'b0, 1'b0);
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got_w[k] !== exp_w[k]) begin
          errors++;
          $display("FAIL latency_model d%0d edge %0d: got %h, want %h", k+1, e, got_w[k], exp_w[k]);
        end
      end
      if (e >= 3 && e <= 6) begin
        checks++;
        if (vo[2] !== 1'b1 || co[2] !== 8'h05 || dout[2] !== 32'(e - 2)) begin
          errors++;
          $display("FAIL latency_d3 edge %0d: got v=%0b c=%h d=%0d, want 1 05 %0d", e, vo[2], co[2], dout[2], e - 2);
        end
      end
      @(negedge clk);
      if (e < 4) drive(1'b1, 8'h05, 32'(e + 1), 1'b0, 1'b0);
      else drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_stall();
    logic [31:0] want;
    drive(1'b1, 8'h05, 32'h10, 1'b0, 1'b0);
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); #1;
      want = (e < 3) ? 32'h10 : 32'h30;
      checks++;
      if (vo[0] !== 1'b1 || dout[0] !== want) begin
        errors++;
        $display("FAIL stall_d1 step %0d: got v=%0b d=%h, want 1 %h", e, vo[0], dout[0], want);
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got_w[k] !== exp_w[k]) begin
          errors++;
          $display("FAIL stall_model d%0d step %0d: got %h, want %h", k+1, e, got_w[k], exp_w[k]);
        end
`ifdef PIPE_REG_STATS_EN
        checks++;
        if (sco[k] !== exp_sc[k]) begin
          errors++;
          $display("FAIL stall_cnt d%0d: got %0d, want %0d", k+1, sco[k], exp_sc[k]);
        end
`endif
      end
      @(negedge clk);
      if (e < 2) drive(1'b1, 8'h05, 32'h20, 1'b1, 1'b0);
      else drive(1'b1, 8'h05, 32'h30, 1'b0, 1'b0);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    drive(1'b1, 8'h09, 32'hA1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'h09, 32'hA2, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (vo[1] !== 1'b1 || co[1] !== 8'h09 || dout[1] !== 32'hA1) begin
      errors++;
      $display("FAIL flush_pre_d2: got v=%0b c=%h d=%h, want 1 09 a1", vo[1], co[1], dout[1]);
    end
    @(negedge clk);
    drive(1'b1, 8'h09, 32'hA3, 1'b1, 1'b1);
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      checks++;
      if (vo[1] !== 1'b0 || co[1] !== 8'h00) begin
        errors++;
        $display("FAIL flush_d2 step %0d: got v=%0b c=%h, want 0 00", e, vo[1], co[1]);
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got_w[k] !== exp_w[k]) begin
          errors++;
          $display("FAIL flush_model d%0d step %0d: got %h, want %h", k+1, e, got_w[k], exp_w[k]);
        end
`ifdef PIPE_REG_STATS_EN
        checks++;
        if (sco[k] !== exp_sc[k]) begin
          errors++;
          $display("FAIL flush_stall_cnt d%0d: got %0d, want %0d", k+1, sco[k], exp_sc[k]);
        end
`endif
      end
      @(negedge clk);
      drive(1'b0, 8'hFF, 32'h0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_invalid();
    drive(1'b0, 8'hFF, 32'h55, 1'b0, 1'b0);
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); #1;
      checks++;
      if (vo[0] !== 1'b0 || co[0] !== 8'h00) begin
        errors++;
        $display("FAIL invalid_d1 step %0d: got v=%0b c=%h, want 0 00", e, vo[0], co[0]);
      end
`ifdef PIPE_REG_STATS_EN
      checks++;
      if (bco[0] !== exp_bc[0] || bco[2] !== exp_bc[2]) begin
        errors++;
        $display("FAIL bubble_cnt step %0d: got %0d/%0d, want %0d/%0d", e, bco[0], bco[2], exp_bc[0], exp_bc[2]);
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(1'b1, 8'h05, 32'h101, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'h05, 32'h102, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'h05, 32'h103, 1'b1, 1'b1);
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({vo[k], co[k], dout[k]} !== 41'h0) begin
        errors++;
        $display("FAIL async_reset d%0d: got v=%0b c=%h d=%h, want all zero", k+1, vo[k], co[k], dout[k]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 8'h01, 32'hAB, 1'b0, 1'b0);
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      checks++;
      if (vo[2] !== (e == 3) || (e == 3 && dout[2] !== 32'hAB)) begin
        errors++;
        $display("FAIL restart_d3 edge %0d: got v=%0b d=%h, want v=%0b", e, vo[2], dout[2], e == 3);
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got_w[k] !== exp_w[k]) begin
          errors++;
          $display("FAIL restart_model d%0d edge %0d: got %h, want %h", k+1, e, got_w[k], exp_w[k]);
        end
      end
      @(negedge clk);
      drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    for (int e = 0; e < 300; e++) begin
      @(negedge clk);
      drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom,
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (got_w[k] !== exp_w[k]) begin
          errors++;
          $display("FAIL random_model d%0d cycle %0d: got %h, want %h", k+1, e, got_w[k], exp_w[k]);
        end
`ifdef PIPE_REG_STATS_EN
        checks++;
        if (sco[k] !== exp_sc[k] || bco[k] !== exp_bc[k]) begin
          errors++;
          $display("FAIL random_cnt d%0d cycle %0d: got %0d/%0d, want %0d/%0d", k+1, e, sco[k], bco[k], exp_sc[k], exp_bc[k]);
        end
`endif
      end
    end
  endtask

  initial begin
    drive(1'b0, 8'h00, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_latency();
    test_stall();
    test_flush();
    test_invalid();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
